mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-fetch requester (icache side) and the data requester (dcache side) of the pipelined core.
- Sequences each RAM transaction with a grant FSM. Drives the per-requester wait signals that feed ihit/dhit into the pipeline stall logic.
- Default policy is fixed data-over-instruction priority. A timeout watchdog flags a hung RAM.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arb_timer.sv | 32 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, grant states and the
// arbitration pick function.
package mem_arbiter_pkg;

  localparam int ARB_MAX_WAIT = 64;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IGNT = 2'd1,
    ARB_DGNT = 2'd2
  } arb_state_t;

  // Data wins unless instruction is preferred and both are requesting.
  function automatic arb_state_t arb_pick(input logic dreq, input logic ireq,
                                          input logic prefer_i);
    arb_state_t pick;
    pick = ARB_IDLE;
    if (dreq && !(ireq && prefer_i)) pick = ARB_DGNT;
    else if (ireq)                   pick = ARB_IGNT;
    return pick;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Grant wait counter: counts stalled granted cycles, flags a timeout on the
// MAX_WAIT-th one and keeps a sticky error flag until reset.
module mem_arb_timer #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic timeout,
  output logic err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt;

  assign timeout = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (!run || restart || timeout) cnt <= '0;
      else                            cnt <= cnt + CNT_W'(1);
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN for last-served fairness instead of fixed data priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int MAX_WAIT = ARB_MAX_WAIT,
  parameter int CNT_W    = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              arb_err,
  output arb_state_t        arb_state
);

  // Handshake: a requester holds its request and address until its wait output
  // drops for one cycle (ramstate==ACCESS); dropping the request early abandons it.

  arb_state_t state, state_next;
  logic dreq, ireq, access, granted, held, run, restart, timeout, prefer_i;

  assign dreq    = dREN | dWEN;
  assign ireq    = iREN;
  assign access  = (ramstate == ACCESS);
  assign granted = (state != ARB_IDLE);
  assign held    = (state == ARB_DGNT) ? dreq : (state == ARB_IGNT) ? ireq : 1'b0;
  assign run     = granted & held & ~access;
  assign restart = (state_next != state);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d, last_d_eff;

  // A completing transfer counts as served for the re-arbitration in the same cycle.
  always_comb begin
    last_d_eff = last_d;
    if (access && state == ARB_DGNT)      last_d_eff = 1'b1;
    else if (access && state == ARB_IGNT) last_d_eff = 1'b0;
  end

  assign prefer_i = last_d_eff;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) last_d <= 1'b1;
    else     last_d <= last_d_eff;
  end
`else
  assign prefer_i = 1'b0;
`endif

  always_comb begin
    state_next = state;
    if (!granted || access || !held || timeout)
      state_next = arb_pick(dreq, ireq, prefer_i);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ARB_IDLE;
    else     state <= state_next;
  end

  mem_arb_timer #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .run    (run),
    .restart(restart),
    .timeout(timeout),
    .err    (arb_err)
  );

  // Enables follow the live request so a flush drops them in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      ARB_DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~access;
        dload    = access ? ramload : '0;
      end
      ARB_IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~access;
        iload   = access ? ramload : '0;
      end
      default: ;
    endcase
  end

  assign arb_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reset checks, a vector table, directed corner sequences
// and randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int MW = 8;
  localparam int CW = 4;
  localparam logic [W-1:0] LD = 32'h8C01_0004;

  logic CLK = 1'b0;
  logic RST;
  logic iREN, dREN, dWEN;
  logic [W-1:0] iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic iwait, dwait, ramREN, ramWEN, arb_err;
  logic [W-1:0] iload, dload, ramaddr, ramstore;
  arb_state_t arb_state;

  mem_arbiter #(.WORD_W(W), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .arb_err(arb_err), .arb_state(arb_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port (0 none, 1 instruction, 2 data), how many granted
  // cycles that ownership has lasted, the sticky error and who was served last.
  int m_owner;
  int m_age;
  bit m_err;
  bit m_last_d;

  task automatic model_reset();
    m_owner  = 0;
    m_age    = 0;
    m_err    = 1'b0;
    m_last_d = 1'b1;
  endtask

  function automatic int pick(bit d, bit i);
    bit pref_i;
`ifdef ARB_ROUND_ROBIN_EN
    pref_i = m_last_d;
`else
    pref_i = 1'b0;
`endif
    if (d && i) return pref_i ? 1 : 2;
    if (d) return 2;
    if (i) return 1;
    return 0;
  endfunction

  task automatic model_check();
    bit acc;
    logic e_ren, e_wen, e_iw, e_dw;
    logic [W-1:0] e_il, e_dl;
    arb_state_t e_st;
    acc = (ramstate == ACCESS);
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_il = '0; e_dl = '0; e_st = ARB_IDLE;
    if (m_owner == 2) begin
      e_st  = ARB_DGNT;
      e_wen = dWEN;
      e_ren = dREN & ~dWEN;
      e_dw  = ~acc;
      e_dl  = acc ? ramload : '0;
      check("m_ramaddr_d", ramaddr, daddr);
      check("m_ramstore", ramstore, dstore);
    end else if (m_owner == 1) begin
      e_st  = ARB_IGNT;
      e_ren = iREN;
      e_iw  = ~acc;
      e_il  = acc ? ramload : '0;
      check("m_ramaddr_i", ramaddr, iaddr);
    end
    check("m_state", arb_state, e_st);
    check("m_ramREN", ramREN, e_ren);
    check("m_ramWEN", ramWEN, e_wen);
    check("m_iwait", iwait, e_iw);
    check("m_dwait", dwait, e_dw);
    check("m_iload", iload, e_il);
    check("m_dload", dload, e_dl);
    check("m_arb_err", arb_err, m_err);
  endtask

  task automatic model_advance();
    bit acc, held, done, tmo;
    acc  = (ramstate == ACCESS);
    held = (m_owner == 2) ? (dREN | dWEN) : (m_owner == 1) ? iREN : 1'b0;
    done = (m_owner != 0) && acc;
    tmo  = (m_owner != 0) && !acc && held && (m_age + 1 >= MW);
    if (done) m_last_d = (m_owner == 2);
    if (tmo) m_err = 1'b1;
    if (m_owner == 0 || done || !held || tmo) begin
      m_owner = pick(dREN | dWEN, iREN);
      m_age   = 0;
    end else begin
      m_age++;
    end
  endtask

  // One clock: drive after the edge, check before the next edge, advance the model.
  task automatic step(input bit ir, input bit dr, input bit dw, input ramstate_t rs,
                      input logic [W-1:0] ia, input logic [W-1:0] da,
                      input logic [W-1:0] ds, input logic [W-1:0] rl);
    @(posedge CLK);
    #2;
    iREN = ir; dREN = dr; dWEN = dw; ramstate = rs;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl;
    #2;
    model_check();
    model_advance();
  endtask

  typedef struct {
    bit ir; bit dr; bit dw; ramstate_t rs; logic [W-1:0] da;
    bit ren; bit wen; bit iw; bit dwt; logic [W-1:0] il; logic [W-1:0] dl; logic [W-1:0] ad;
  } vec_t;

  vec_t tbl[11];
  ramstate_t rs_r;
  int r;

  initial begin
    // Single fetch at 0x40 with three BUSY cycles, then a write to 0x200.
    tbl[0]  = '{1, 0, 0, FREE,   32'h200, 0, 0, 1, 1, 0,  0,  0};
    tbl[1]  = '{1, 0, 0, BUSY,   32'h200, 1, 0, 1, 1, 0,  0,  32'h40};
    tbl[2]  = '{1, 0, 0, BUSY,   32'h200, 1, 0, 1, 1, 0,  0,  32'h40};
    tbl[3]  = '{1, 0, 0, BUSY,   32'h200, 1, 0, 1, 1, 0,  0,  32'h40};
    tbl[4]  = '{1, 0, 0, ACCESS, 32'h200, 1, 0, 0, 1, LD, 0,  32'h40};
    tbl[5]  = '{0, 0, 0, FREE,   32'h200, 0, 0, 1, 1, 0,  0,  0};
    tbl[6]  = '{0, 0, 0, FREE,   32'h200, 0, 0, 1, 1, 0,  0,  0};
    tbl[7]  = '{0, 0, 1, FREE,   32'h200, 0, 0, 1, 1, 0,  0,  0};
    tbl[8]  = '{0, 0, 1, BUSY,   32'h200, 0, 1, 1, 1, 0,  0,  32'h200};
    tbl[9]  = '{0, 0, 1, ACCESS, 32'h200, 0, 1, 1, 0, 0,  LD, 32'h200};
    tbl[10] = '{0, 0, 0, FREE,   32'h200, 0, 0, 1, 1, 0,  0,  0};

    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    iaddr = 32'h40; daddr = 32'h200; dstore = 32'hDEADBEEF; ramload = LD;
    model_reset();
    #12;
    check("rst_state", arb_state, ARB_IDLE);
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_ramWEN", ramWEN, 1'b0);
    check("rst_iwait", iwait, 1'b1);
    check("rst_dwait", dwait, 1'b1);
    check("rst_iload", iload, '0);
    check("rst_dload", dload, '0);
    check("rst_arb_err", arb_err, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    for (int k = 0; k < 11; k++) begin
      step(tbl[k].ir, tbl[k].dr, tbl[k].dw, tbl[k].rs, 32'h40, tbl[k].da, 32'hDEADBEEF, LD);
      check($sformatf("tbl%0d_ramREN", k), ramREN, tbl[k].ren);
      check($sformatf("tbl%0d_ramWEN", k), ramWEN, tbl[k].wen);
      check($sformatf("tbl%0d_iwait", k), iwait, tbl[k].iw);
      check($sformatf("tbl%0d_dwait", k), dwait, tbl[k].dwt);
      check($sformatf("tbl%0d_iload", k), iload, tbl[k].il);
      check($sformatf("tbl%0d_dload", k), dload, tbl[k].dl);
      if (tbl[k].ren || tbl[k].wen) check($sformatf("tbl%0d_ramaddr", k), ramaddr, tbl[k].ad);
      if (tbl[k].wen) check($sformatf("tbl%0d_ramstore", k), ramstore, 32'hDEADBEEF);
    end

    // Contention: both request together; the loser is served right after.
    step(1, 1, 0, FREE, 32'h40, 32'h100, 0, LD);
    step(1, 1, 0, BUSY, 32'h40, 32'h100, 0, LD);
`ifdef ARB_ROUND_ROBIN_EN
    check("cont_first", arb_state, ARB_IGNT);
    check("cont_first_addr", ramaddr, 32'h40);
    step(0, 1, 0, ACCESS, 32'h40, 32'h100, 0, LD);
    step(0, 1, 0, BUSY, 32'h40, 32'h100, 0, LD);
    check("cont_second", arb_state, ARB_DGNT);
    check("cont_second_addr", ramaddr, 32'h100);
    step(0, 1, 0, ACCESS, 32'h40, 32'h100, 0, LD);
`else
    check("cont_first", arb_state, ARB_DGNT);
    check("cont_first_addr", ramaddr, 32'h100);
    step(1, 0, 0, ACCESS, 32'h40, 32'h100, 0, LD);
    step(1, 0, 0, BUSY, 32'h40, 32'h100, 0, LD);
    check("cont_second", arb_state, ARB_IGNT);
    check("cont_second_addr", ramaddr, 32'h40);
    step(1, 0, 0, ACCESS, 32'h40, 32'h100, 0, LD);
`endif
    step(0, 0, 0, FREE, 32'h40, 32'h100, 0, LD);
    step(0, 0, 0, FREE, 32'h40, 32'h100, 0, LD);

    // Flush: data read abandoned after two BUSY cycles while a fetch waits.
    step(0, 1, 0, FREE, 32'h44, 32'h300, 0, LD);
    step(1, 1, 0, BUSY, 32'h44, 32'h300, 0, LD);
    step(1, 1, 0, BUSY, 32'h44, 32'h300, 0, LD);
    step(1, 0, 0, BUSY, 32'h44, 32'h300, 0, LD);
    check("flush_ren_drop", ramREN, 1'b0);
    step(1, 0, 0, BUSY, 32'h44, 32'h300, 0, LD);
    check("flush_ignt", arb_state, ARB_IGNT);
    check("flush_addr", ramaddr, 32'h44);
    step(1, 0, 0, ACCESS, 32'h44, 32'h300, 0, LD);
    step(0, 0, 0, FREE, 32'h44, 32'h300, 0, LD);
    step(0, 0, 0, FREE, 32'h44, 32'h300, 0, LD);

    // Timeout: RAM stuck BUSY for MW granted cycles.
    step(0, 1, 0, FREE, 32'h40, 32'h400, 0, LD);
    for (int k = 1; k <= MW; k++) begin
      step(0, 1, 0, BUSY, 32'h40, 32'h400, 0, LD);
      check($sformatf("tmo_err_pre%0d", k), arb_err, 1'b0);
    end
    step(0, 0, 0, BUSY, 32'h40, 32'h400, 0, LD);
    check("tmo_err_set", arb_err, 1'b1);
    step(0, 0, 0, FREE, 32'h40, 32'h400, 0, LD);
    step(0, 0, 0, FREE, 32'h40, 32'h400, 0, LD);
    check("tmo_err_sticky", arb_err, 1'b1);

    // Reset in the middle of a BUSY write.
    step(0, 0, 1, FREE, 32'h40, 32'h500, 32'h1234, LD);
    step(0, 0, 1, BUSY, 32'h40, 32'h500, 32'h1234, LD);
    check("mid_wen_before", ramWEN, 1'b1);
    #1 RST = 1'b1;
    #1;
    check("mid_rst_ramWEN", ramWEN, 1'b0);
    check("mid_rst_dwait", dwait, 1'b1);
    check("mid_rst_arb_err", arb_err, 1'b0);
    check("mid_rst_state", arb_state, ARB_IDLE);
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    model_reset();
    @(posedge CLK);
    #2 RST = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      rs_r = FREE;
      else if (r < 6) rs_r = BUSY;
      else if (r < 9) rs_r = ACCESS;
      else            rs_r = ERROR;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           rs_r, $urandom, $urandom, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
